tia_audio_gen: RTL and testbench

Parametrised Atari 2600 audio generator: N independent TIA-compatible tone/noise channels with full AUDC polynomial modes, per-channel volume, a mixed PCM output and per-channel first-order delta-sigma 1-bit outputs. Sits beside the TIA video core on the same register bus and replaces its square-wave-only audio path; it is clocked by the system clock and paced by the colour-clock enable.

---
 rtl/tia_audio_gen_pkg.sv | 52 +++++
 rtl/tia_audio_gen_chan.sv | 136 +++++++++++++
 rtl/tia_audio_gen.sv | 108 ++++++++++
 tb/tb_tia_audio_gen.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tia_audio_gen_pkg.sv
// Shared constants for the TIA-compatible audio generator: AUDC modes,
// pre-divider moduli, register banks and the LFSR step functions.
package tia_audio_gen_pkg;

  localparam int AUDC_W = 4;
  localparam int AUDF_W = 5;
  localparam int PD_W   = 7;

  typedef enum logic [3:0] {
    AUDC_SET1    = 4'd0,
    AUDC_POLY4   = 4'd1,
    AUDC_DIV15P4 = 4'd2,
    AUDC_P5P4    = 4'd3,
    AUDC_DIV2A   = 4'd4,
    AUDC_DIV2B   = 4'd5,
    AUDC_DIV31A  = 4'd6,
    AUDC_P5DIV2  = 4'd7,
    AUDC_POLY9   = 4'd8,
    AUDC_POLY5   = 4'd9,
    AUDC_DIV31B  = 4'd10,
    AUDC_SET1B   = 4'd11,
    AUDC_DIV6A   = 4'd12,
    AUDC_DIV6B   = 4'd13,
    AUDC_DIV93   = 4'd14,
    AUDC_P5DIV6  = 4'd15
  } audc_mode_e;

  localparam logic [PD_W-1:0] MOD_3       = 7'd3;
  localparam logic [PD_W-1:0] MOD_15      = 7'd15;
  localparam logic [PD_W-1:0] MOD_31      = 7'd31;
  localparam logic [PD_W-1:0] MOD_93      = 7'd93;
  localparam logic [PD_W-1:0] MOD_31_HALF = 7'd15;

  // Register banks; address offset = bank * NUM_CH + channel
  localparam int BANK_AUDC = 0;
  localparam int BANK_AUDF = 1;
  localparam int BANK_AUDV = 2;

  // Left-shifting Fibonacci LFSRs, feedback into bit 0
  function automatic logic [3:0] poly4_step(input logic [3:0] s);
    return {s[2:0], s[3] ^ s[2]};
  endfunction

  function automatic logic [4:0] poly5_step(input logic [4:0] s);
    return {s[3:0], s[4] ^ s[2]};
  endfunction

  function automatic logic [8:0] poly9_step(input logic [8:0] s);
    return {s[7:0], s[8] ^ s[4]};
  endfunction

endpackage

// File: rtl/tia_audio_gen_chan.sv
// One TIA audio channel: frequency counter, pre-divider, poly4/5/9 LFSRs,
// AUDC mode decode, volume-gated sample and a first-order delta-sigma bit.
module tia_audio_gen_chan
  import tia_audio_gen_pkg::*;
#(
  parameter int VOL_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              tick_i,
  input  logic [AUDC_W-1:0] audc_i,
  input  logic [AUDF_W-1:0] audf_i,
  input  logic [VOL_W-1:0]  audv_i,
  output logic [VOL_W-1:0]  sample_o,
  output logic              pdm_o
);

  logic [AUDF_W-1:0] fc_r;
  logic [PD_W-1:0]   pd_r, pd_nx_s, mod_s;
  logic [3:0]        p4_r, p4_nx_s;
  logic [4:0]        p5_r, p5_nx_s;
  logic [8:0]        p9_r, p9_nx_s;
  logic              out_r, out_nx_s;
  logic [VOL_W-1:0]  acc_r;
  logic              pdm_r;
  logic              cclk_s, pd_cnt_s, pd_wrap_s;
  audc_mode_e        mode_s;

  assign mode_s    = audc_mode_e'(audc_i);
  assign cclk_s    = tick_i && (fc_r >= audf_i);
  assign pd_wrap_s = (pd_r >= (mod_s - 7'd1));
  assign sample_o  = out_r ? audv_i : {VOL_W{1'b0}};
  assign pdm_o     = pdm_r;

  // Pre-divider modulus and count enable for the current mode
  always_comb begin
    mod_s    = MOD_3;
    pd_cnt_s = 1'b0;
    case (mode_s)
      AUDC_DIV15P4:              begin mod_s = MOD_15; pd_cnt_s = 1'b1;    end
      AUDC_DIV31A, AUDC_DIV31B:  begin mod_s = MOD_31; pd_cnt_s = 1'b1;    end
      AUDC_DIV6A, AUDC_DIV6B:    begin mod_s = MOD_3;  pd_cnt_s = 1'b1;    end
      AUDC_DIV93:                begin mod_s = MOD_93; pd_cnt_s = 1'b1;    end
      AUDC_P5DIV6:               begin mod_s = MOD_3;  pd_cnt_s = p5_r[4]; end
      default:                   begin mod_s = MOD_3;  pd_cnt_s = 1'b0;    end
    endcase
  end

  // Next generator state on a channel clock
  always_comb begin
    pd_nx_s  = pd_r;
    p4_nx_s  = p4_r;
    p5_nx_s  = p5_r;
    p9_nx_s  = p9_r;
    out_nx_s = out_r;
    if (cclk_s) begin
      if (pd_cnt_s) begin
        pd_nx_s = pd_wrap_s ? 7'd0 : pd_r + 7'd1;
      end else begin
        pd_nx_s = pd_r;
      end
      case (mode_s)
        AUDC_SET1, AUDC_SET1B: out_nx_s = 1'b1;
        AUDC_POLY4: begin
          p4_nx_s  = poly4_step(p4_r);
          out_nx_s = p4_nx_s[3];
        end
        AUDC_DIV15P4: begin
          p4_nx_s  = pd_wrap_s ? poly4_step(p4_r) : p4_r;
          out_nx_s = p4_nx_s[3];
        end
        AUDC_P5P4: begin
          p5_nx_s  = poly5_step(p5_r);
          p4_nx_s  = p5_r[4] ? poly4_step(p4_r) : p4_r;
          out_nx_s = p4_nx_s[3];
        end
        AUDC_DIV2A, AUDC_DIV2B: out_nx_s = ~out_r;
        // Two toggles per 31 clocks give the 15/16 half-periods
        AUDC_DIV31A, AUDC_DIV31B:
          out_nx_s = (pd_wrap_s || (pd_r == (MOD_31_HALF - 7'd1))) ? ~out_r : out_r;
        AUDC_P5DIV2: begin
          p5_nx_s  = poly5_step(p5_r);
          out_nx_s = p5_r[4] ? ~out_r : out_r;
        end
        AUDC_POLY9: begin
          p9_nx_s  = poly9_step(p9_r);
          out_nx_s = p9_nx_s[8];
        end
        AUDC_POLY5: begin
          p5_nx_s  = poly5_step(p5_r);
          out_nx_s = p5_nx_s[4];
        end
        AUDC_DIV6A, AUDC_DIV6B, AUDC_DIV93: out_nx_s = pd_wrap_s ? ~out_r : out_r;
        AUDC_P5DIV6: begin
          p5_nx_s  = poly5_step(p5_r);
          out_nx_s = (p5_r[4] && pd_wrap_s) ? ~out_r : out_r;
        end
        default: out_nx_s = out_r;
      endcase
    end else begin
      out_nx_s = out_r;
    end
  end

  // Channel state registers; LFSRs seed to all-ones
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fc_r  <= 5'd0;
      pd_r  <= 7'd0;
      p4_r  <= 4'hF;
      p5_r  <= 5'h1F;
      p9_r  <= 9'h1FF;
      out_r <= 1'b0;
    end else begin
      if (tick_i) begin
        fc_r <= cclk_s ? 5'd0 : fc_r + 5'd1;
      end
      pd_r  <= pd_nx_s;
      p4_r  <= p4_nx_s;
      p5_r  <= p5_nx_s;
      p9_r  <= p9_nx_s;
      out_r <= out_nx_s;
    end
  end

  // Delta-sigma: the carry out of the accumulator is the 1-bit output
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_r <= {VOL_W{1'b0}};
      pdm_r <= 1'b0;
    end else begin
      {pdm_r, acc_r} <= {1'b0, acc_r} + {1'b0, sample_o};
    end
  end

endmodule

// File: rtl/tia_audio_gen.sv
// Multi-channel TIA audio generator: tick divider, write-only register bank,
// per-channel generators and the summed PCM output.
module tia_audio_gen
  import tia_audio_gen_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int VOL_W      = 4,
  parameter int AUD_DIV    = 114,
  parameter int ADDR_BASE  = 'h15,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              enable_i,
  input  logic                              stb_i,
  input  logic                              we_i,
  input  logic [ADDR_WIDTH-1:0]             adr_i,
  input  logic [7:0]                        dat_i,
  output logic                              tick_o,
  output logic [VOL_W+$clog2(NUM_CH):0]     pcm_o,
  output logic [NUM_CH-1:0]                 pdm_o
);

  localparam int PCM_W = VOL_W + $clog2(NUM_CH) + 1;
  localparam int DIV_W = $clog2(AUD_DIV + 1);

  logic [DIV_W-1:0]      div_r;
  logic                  tick_s, tick_r, wr_s;
  logic [ADDR_WIDTH-1:0] off_s;
  logic [AUDC_W-1:0]     audc_r [NUM_CH];
  logic [AUDF_W-1:0]     audf_r [NUM_CH];
  logic [VOL_W-1:0]      audv_r [NUM_CH];
  logic [VOL_W-1:0]      sample_s [NUM_CH];
  logic [NUM_CH-1:0]     pdm_s;
  logic [PCM_W-1:0]      sum_s, pcm_r;
  logic                  unused_dat_s;

  assign tick_s       = enable_i && (div_r == DIV_W'(AUD_DIV - 1));
  assign wr_s         = stb_i && we_i;
  assign off_s        = adr_i - ADDR_WIDTH'(ADDR_BASE);
  assign unused_dat_s = ^dat_i[7:5];
  assign tick_o       = tick_r;
  assign pcm_o        = pcm_r;
  assign pdm_o        = pdm_s;

  // Colour-clock divider producing one tick per AUD_DIV enables
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_r  <= {DIV_W{1'b0}};
      tick_r <= 1'b0;
    end else begin
      if (enable_i) begin
        div_r <= tick_s ? {DIV_W{1'b0}} : div_r + DIV_W'(1);
      end
      tick_r <= tick_s;
    end
  end

  // Register bank; out-of-map offsets (including below ADDR_BASE) never match
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int n = 0; n < NUM_CH; n++) begin
        audc_r[n] <= 4'd0;
        audf_r[n] <= 5'd0;
        audv_r[n] <= {VOL_W{1'b0}};
      end
    end else if (wr_s) begin
      for (int n = 0; n < NUM_CH; n++) begin
        if (off_s == ADDR_WIDTH'(BANK_AUDC * NUM_CH + n)) audc_r[n] <= dat_i[3:0];
        if (off_s == ADDR_WIDTH'(BANK_AUDF * NUM_CH + n)) audf_r[n] <= dat_i[4:0];
        if (off_s == ADDR_WIDTH'(BANK_AUDV * NUM_CH + n)) audv_r[n] <= dat_i[VOL_W-1:0];
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    tia_audio_gen_chan #(
      .VOL_W(VOL_W)
    ) u_chan (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .tick_i   (tick_s),
      .audc_i   (audc_r[g]),
      .audf_i   (audf_r[g]),
      .audv_i   (audv_r[g]),
      .sample_o (sample_s[g]),
      .pdm_o    (pdm_s[g])
    );
  end

  // Sum of all channel samples
  always_comb begin
    sum_s = {PCM_W{1'b0}};
    for (int n = 0; n < NUM_CH; n++) begin
      sum_s = sum_s + PCM_W'(sample_s[n]);
    end
  end

  // Registered PCM output
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pcm_r <= {PCM_W{1'b0}};
    end else begin
      pcm_r <= sum_s;
    end
  end

endmodule

// File: tb/tb_tia_audio_gen.sv
// Scoreboard bench for tia_audio_gen: expected per-tick PCM values are queued
// when a tone is configured and compared one clock after each tick_o.
module tb_tia_audio_gen;

  localparam int NUM_CH     = 2;
  localparam int VOL_W      = 4;
  localparam int AUD_DIV    = 114;
  localparam int ADDR_BASE  = 'h15;
  localparam int ADDR_WIDTH = 7;
  localparam int PCM_W      = VOL_W + $clog2(NUM_CH) + 1;

  localparam int A_AUDC0 = ADDR_BASE;
  localparam int A_AUDC1 = ADDR_BASE + 1;
  localparam int A_AUDF0 = ADDR_BASE + 2;
  localparam int A_AUDF1 = ADDR_BASE + 3;
  localparam int A_AUDV0 = ADDR_BASE + 4;
  localparam int A_AUDV1 = ADDR_BASE + 5;
  localparam int A_BAD   = ADDR_BASE + 3 * NUM_CH;

  logic                  clk = 1'b0;
  logic                  rst_ni = 1'b1;
  logic                  enable_i = 1'b0;
  logic                  stb_i = 1'b0;
  logic                  we_i = 1'b0;
  logic [ADDR_WIDTH-1:0] adr_i = '0;
  logic [7:0]            dat_i = '0;
  logic                  tick_o;
  logic [PCM_W-1:0]      pcm_o;
  logic [NUM_CH-1:0]     pdm_o;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int exp_q[$];
  int tick_q[$];

  always #5 clk = ~clk;

  tia_audio_gen #(
    .NUM_CH(NUM_CH), .VOL_W(VOL_W), .AUD_DIV(AUD_DIV),
    .ADDR_BASE(ADDR_BASE), .ADDR_WIDTH(ADDR_WIDTH)
  ) u_dut (
    .clk_i(clk), .rst_ni(rst_ni), .enable_i(enable_i), .stb_i(stb_i),
    .we_i(we_i), .adr_i(adr_i), .dat_i(dat_i), .tick_o(tick_o),
    .pcm_o(pcm_o), .pdm_o(pdm_o)
  );

  task automatic check(input string tag, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic reg_wr(input int adr, input int dat);
    stb_i = 1'b1; we_i = 1'b1;
    adr_i = ADDR_WIDTH'(adr); dat_i = 8'(dat);
    step();
    stb_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic do_reset();
    enable_i = 1'b0;
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    step();
  endtask

  task automatic wait_tick(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3 * AUD_DIV; i++) begin
      step();
      if (tick_o) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("tick_timeout", 0, 1);
  endtask

  // Run n ticks, comparing pcm_o one clock after each tick against the queue
  task automatic run_ticks(input int n, input string tag);
    bit ok;
    int e;
    enable_i = 1'b1;
    for (int k = 0; k < n; k++) begin
      wait_tick(ok);
      if (!ok) break;
      step();
      e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
      check(tag, int'(pcm_o), e);
    end
    check({tag, "_drain"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic count_pdm(input int bitn, input int exp, input string tag);
    int ones = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      ones += int'(pdm_o[bitn]);
    end
    check(tag, ones, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int en_cnt;
    int n_ticks;
    int e;
    logic [8:0] p9;
    logic [3:0] p4;

    // Asynchronous reset before any clock edge
    #1 rst_ni = 1'b0;
    #2;
    check("rst_tick", int'(tick_o), 0);
    check("rst_pcm", int'(pcm_o), 0);
    check("rst_pdm", int'(pdm_o), 0);
    step();
    rst_ni = 1'b1;
    step();

    // Tick divider with irregular enables
    en_cnt = 0;
    n_ticks = 0;
    for (int c = 0; c < 8000; c++) begin
      enable_i = ($urandom_range(0, 1) == 1);
      if (enable_i) begin
        en_cnt++;
        if (en_cnt % AUD_DIV == 0) tick_q.push_back(cyc + 1);
      end
      step();
      if (tick_o) begin
        e = (tick_q.size() > 0) ? tick_q.pop_front() : -1;
        check("tick_cycle", cyc, e);
        check("tick_pcm", int'(pcm_o), 0);
        check("tick_pdm", int'(pdm_o), 0);
        n_ticks++;
      end
      if (n_ticks == 20) break;
    end
    check("tick_count", n_ticks, 20);
    check("tick_pending", tick_q.size(), 0);

    // Mode 4, AUDF=0: toggle every tick, then delta-sigma duty
    do_reset();
    reg_wr(A_AUDC0, 4); reg_wr(A_AUDF0, 0); reg_wr(A_AUDV0, 15);
    for (int k = 0; k < 5; k++) exp_q.push_back((k % 2 == 0) ? 15 : 0);
    run_ticks(5, "div2");
    count_pdm(0, 15, "pdm_duty_hi");
    count_pdm(1, 0, "pdm1_silent");
    exp_q.push_back(0);
    run_ticks(1, "div2_lo");
    count_pdm(0, 0, "pdm_duty_lo");

    // Mode 4, AUDF=9, then AUDF=2 written while fc=5
    do_reset();
    reg_wr(A_AUDC0, 4); reg_wr(A_AUDF0, 9); reg_wr(A_AUDV0, 15);
    for (int k = 1; k <= 25; k++) exp_q.push_back((k >= 10 && k < 20) ? 15 : 0);
    run_ticks(25, "div10");
    reg_wr(A_AUDF0, 2);
    for (int k = 26; k <= 32; k++) exp_q.push_back((k <= 28 || k == 32) ? 15 : 0);
    run_ticks(7, "audf_change");

    // Mode 12: toggle every third channel clock
    do_reset();
    reg_wr(A_AUDC0, 12); reg_wr(A_AUDV0, 15);
    for (int k = 1; k <= 9; k++) exp_q.push_back(((k / 3) % 2 == 1) ? 15 : 0);
    run_ticks(9, "div6");

    // Mode 6: 15/16 half-periods
    do_reset();
    reg_wr(A_AUDC0, 6); reg_wr(A_AUDV0, 15);
    for (int k = 1; k <= 31; k++) exp_q.push_back((k >= 15 && k <= 30) ? 15 : 0);
    run_ticks(31, "div31");

    // Mixing, and an AUDV write coincident with a tick
    do_reset();
    reg_wr(A_AUDC0, 0); reg_wr(A_AUDC1, 0);
    reg_wr(A_AUDV0, 15); reg_wr(A_AUDV1, 15);
    exp_q.push_back(30);
    run_ticks(1, "mix");
    for (int i = 0; i < AUD_DIV - 2; i++) step();
    stb_i = 1'b1; we_i = 1'b1; adr_i = ADDR_WIDTH'(A_AUDV0); dat_i = 8'd5;
    step();
    stb_i = 1'b0; we_i = 1'b0;
    check("mix_tick_same_cycle", int'(tick_o), 1);
    check("mix_old_audv", int'(pcm_o), 30);
    step();
    check("mix_new_audv", int'(pcm_o), 20);

    // Asynchronous reset mid-tone, then a write outside the register map
    #2 rst_ni = 1'b0;
    #1;
    check("async_rst_pcm", int'(pcm_o), 0);
    check("async_rst_pdm", int'(pdm_o), 0);
    #1 rst_ni = 1'b1;
    step();
    reg_wr(A_BAD, 8'hFF);
    exp_q.push_back(0);
    run_ticks(1, "bad_addr");

    // Channel 1 poly9 against a software LFSR
    do_reset();
    reg_wr(A_AUDC1, 8); reg_wr(A_AUDF1, 0); reg_wr(A_AUDV1, 15);
    p9 = 9'h1FF;
    for (int k = 0; k < 30; k++) begin
      p9 = {p9[7:0], p9[8] ^ p9[4]};
      exp_q.push_back(p9[8] ? 15 : 0);
    end
    run_ticks(30, "poly9");

    // Reset mid-sequence must reload the LFSR seed
    #2 rst_ni = 1'b0;
    #1;
    check("poly_rst_pcm", int'(pcm_o), 0);
    #1 rst_ni = 1'b1;
    step();
    reg_wr(A_AUDC1, 8); reg_wr(A_AUDF1, 0); reg_wr(A_AUDV1, 15);
    p9 = 9'h1FF;
    for (int k = 0; k < 12; k++) begin
      p9 = {p9[7:0], p9[8] ^ p9[4]};
      exp_q.push_back(p9[8] ? 15 : 0);
    end
    run_ticks(12, "poly9_reseed");

    // Switch to poly4 without re-seeding; poly4 has not shifted yet
    reg_wr(A_AUDC1, 1);
    p4 = 4'hF;
    for (int k = 0; k < 30; k++) begin
      p4 = {p4[2:0], p4[3] ^ p4[2]};
      exp_q.push_back(p4[3] ? 15 : 0);
    end
    run_ticks(30, "poly4");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
